// File: rtl/dmem_arbiter.sv
// Shares the single data-memory port between the CPU MEM stage and a DMA/loader.
// The CPU has priority; a saturating wait counter forces a DMA grant after MAX_WAIT lost cycles.
module dmem_arbiter #(
   parameter int MAX_WAIT = 4
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        cpu_mem_read,
   input  logic        cpu_mem_write,
   input  logic [31:0] cpu_addr,
   input  logic [31:0] cpu_wdata,
   output logic [31:0] cpu_rdata,
   output logic        cpu_stall,
   input  logic        dma_valid,
   input  logic        dma_we,
   input  logic [31:0] dma_addr,
   input  logic [31:0] dma_wdata,
   output logic        dma_ready,
   output logic        dma_rvalid,
   output logic [31:0] dma_rdata,
   output logic        mem_we,
   output logic [31:0] mem_addr,
   output logic [31:0] mem_wd,
   input  logic [31:0] mem_rd
);

   localparam logic [3:0] WAIT_LIMIT = 4'(MAX_WAIT);

   logic [3:0]  wait_cnt_reg;
   logic [3:0]  wait_cnt_next;
   logic        cpu_req;
   logic        dma_grant;
   logic        dma_rd_accept;
   logic        dma_rvalid_reg;
   logic [31:0] dma_rdata_reg;

   // Grant decision and port mux; the idle/reset default keeps the CPU fields on the port.
   always_comb begin
      cpu_req       = cpu_mem_read | cpu_mem_write;
      dma_grant     = 1'b0;
      dma_ready     = 1'b0;
      cpu_stall     = 1'b0;
      mem_we        = 1'b0;
      mem_addr      = cpu_addr;
      mem_wd        = cpu_wdata;
      wait_cnt_next = wait_cnt_reg;
      if (rst) begin
         wait_cnt_next = 4'd0;
      end else begin
         dma_grant = dma_valid && (!cpu_req || (wait_cnt_reg >= WAIT_LIMIT));
         if (dma_grant) begin
            dma_ready = 1'b1;
            cpu_stall = cpu_req;
            mem_we    = dma_we;
            mem_addr  = dma_addr;
            mem_wd    = dma_wdata;
         end else begin
            mem_we = cpu_mem_write;
         end
         // The counter only advances on cycles the DMA actually loses to the CPU.
         if (!dma_valid || dma_grant) begin
            wait_cnt_next = 4'd0;
         end else if (wait_cnt_reg < WAIT_LIMIT) begin
            wait_cnt_next = wait_cnt_reg + 4'd1;
         end
      end
   end

   assign dma_rd_accept = dma_ready & ~dma_we;

   always_ff @(posedge clk) begin
      if (rst) begin
         wait_cnt_reg   <= 4'd0;
         dma_rvalid_reg <= 1'b0;
         dma_rdata_reg  <= 32'd0;
      end else begin
         wait_cnt_reg   <= wait_cnt_next;
         dma_rvalid_reg <= dma_rd_accept;
         if (dma_rd_accept) begin
            dma_rdata_reg <= mem_rd;
         end
      end
   end

   assign cpu_rdata  = mem_rd;
   assign dma_rvalid = dma_rvalid_reg;
   assign dma_rdata  = dma_rdata_reg;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Scoreboard bench for dmem_arbiter: a transaction-level model predicts each cycle's grant
// and DMA read responses; a monitor compares them against a MAX_WAIT=4 instance.
module tb_dmem_arbiter;
   localparam int MAX_WAIT = 4;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        rst, cpu_mem_read, cpu_mem_write, dma_valid, dma_we;
   logic [31:0] cpu_addr, cpu_wdata, dma_addr, dma_wdata;
   logic [31:0] cpu_rdata, dma_rdata, mem_addr, mem_wd, mem_rd;
   logic        cpu_stall, dma_ready, dma_rvalid, mem_we;

   logic        rst0, cpu_mem_read0, cpu_mem_write0, dma_valid0, dma_we0;
   logic [31:0] cpu_addr0, cpu_wdata0, dma_addr0, dma_wdata0;
   logic [31:0] cpu_rdata0, dma_rdata0, mem_addr0, mem_wd0, mem_rd0;
   logic        cpu_stall0, dma_ready0, dma_rvalid0, mem_we0;

   dmem_arbiter #(.MAX_WAIT(MAX_WAIT)) u_dut (
      .clk(clk), .rst(rst),
      .cpu_mem_read(cpu_mem_read), .cpu_mem_write(cpu_mem_write),
      .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata), .cpu_rdata(cpu_rdata), .cpu_stall(cpu_stall),
      .dma_valid(dma_valid), .dma_we(dma_we), .dma_addr(dma_addr), .dma_wdata(dma_wdata),
      .dma_ready(dma_ready), .dma_rvalid(dma_rvalid), .dma_rdata(dma_rdata),
      .mem_we(mem_we), .mem_addr(mem_addr), .mem_wd(mem_wd), .mem_rd(mem_rd)
   );

   dmem_arbiter #(.MAX_WAIT(0)) u_dut0 (
      .clk(clk), .rst(rst0),
      .cpu_mem_read(cpu_mem_read0), .cpu_mem_write(cpu_mem_write0),
      .cpu_addr(cpu_addr0), .cpu_wdata(cpu_wdata0), .cpu_rdata(cpu_rdata0), .cpu_stall(cpu_stall0),
      .dma_valid(dma_valid0), .dma_we(dma_we0), .dma_addr(dma_addr0), .dma_wdata(dma_wdata0),
      .dma_ready(dma_ready0), .dma_rvalid(dma_rvalid0), .dma_rdata(dma_rdata0),
      .mem_we(mem_we0), .mem_addr(mem_addr0), .mem_wd(mem_wd0), .mem_rd(mem_rd0)
   );
   assign mem_rd0 = 32'h0;

   // Data memory attached to the main instance: combinational read, write on the edge.
   logic [31:0] dmem [0:255];
   logic        mem_init;
   assign mem_rd = dmem[mem_addr[9:2]];
   always @(posedge clk) begin
      if (mem_init) begin
         for (int i = 0; i < 256; i++) dmem[i] <= 32'h0;
      end else if (mem_we) begin
         dmem[mem_addr[9:2]] <= mem_wd;
      end
   end

   typedef struct {
      bit rst; bit cr; bit cw; logic [31:0] ca; logic [31:0] cwd;
      bit dv; bit dwe; logic [31:0] da; logic [31:0] dwd;
   } stim_t;
   typedef struct {
      bit ready; bit stall; bit we; logic [31:0] addr; logic [31:0] wd;
      bit chk_load; logic [31:0] load;
   } exp_t;
   typedef struct { int cyc; logic [31:0] data; } rd_t;

   exp_t        cycq[$];
   rd_t         rdq[$];
   logic [31:0] ref_mem [0:255];
   int          errs = 0, checks = 0, cyc = 0;
   bit          mon_en = 1'b0;
   int          losses = 0;
   bit          prev_stall = 1'b0, prev_hold = 1'b0;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         errs++;
         $display("FAIL %s cycle=%0d actual=%h required=%h", name, cyc, act, req);
      end
   endtask

   function automatic stim_t mk(input bit r, input bit cr, input bit cw, input logic [31:0] ca,
                                input logic [31:0] cwd, input bit dv, input bit dwe,
                                input logic [31:0] da, input logic [31:0] dwd);
      stim_t s;
      s.rst = r; s.cr = cr; s.cw = cw; s.ca = ca; s.cwd = cwd;
      s.dv = dv; s.dwe = dwe; s.da = da; s.dwd = dwd;
      return s;
   endfunction

   // Apply one cycle of stimulus and push what the arbitration rules predict for it.
   task automatic step(input stim_t s);
      exp_t e;
      bit   cpu_req, dma_wins;
      @(posedge clk); #1;
      rst = s.rst; cpu_mem_read = s.cr; cpu_mem_write = s.cw; cpu_addr = s.ca; cpu_wdata = s.cwd;
      dma_valid = s.dv; dma_we = s.dwe; dma_addr = s.da; dma_wdata = s.dwd;
      mon_en = 1'b1;
      cpu_req = s.cr | s.cw;
      e = '{default: 0};
      e.addr = s.ca;
      e.wd = s.cwd;
      if (s.rst) begin
         losses = 0;
         prev_stall = 1'b0;
         prev_hold = s.dv;
      end else begin
         dma_wins = s.dv && (!cpu_req || losses == MAX_WAIT);
         if (dma_wins) begin
            e.ready = 1'b1; e.stall = cpu_req; e.we = s.dwe; e.addr = s.da; e.wd = s.dwd;
            if (s.dwe) ref_mem[s.da[9:2]] = s.dwd;
            else rdq.push_back('{cyc + 1, ref_mem[s.da[9:2]]});
            losses = 0;
         end else begin
            e.we = s.cw;
            e.chk_load = s.cr;
            e.load = ref_mem[s.ca[9:2]];
            if (s.cw) ref_mem[s.ca[9:2]] = s.cwd;
            losses = s.dv ? losses + 1 : 0;
         end
         prev_stall = e.stall;
         prev_hold = s.dv && !dma_wins;
      end
      cycq.push_back(e);
   endtask

   always @(negedge clk) begin : monitor
      exp_t e;
      rd_t  r;
      if (mon_en) begin
         while (cycq.size() > 0) begin
            e = cycq.pop_front();
            check("dma_ready", 32'(dma_ready), 32'(e.ready));
            check("cpu_stall", 32'(cpu_stall), 32'(e.stall));
            check("mem_we", 32'(mem_we), 32'(e.we));
            check("mem_addr", mem_addr, e.addr);
            if (e.we) check("mem_wd", mem_wd, e.wd);
            if (e.chk_load) check("cpu_rdata", cpu_rdata, e.load);
         end
         if (dma_rvalid) begin
            if (rdq.size() == 0) begin
               check("dma_rvalid_unexpected", 32'(dma_rvalid), 32'd0);
            end else begin
               r = rdq.pop_front();
               check("dma_rvalid_cycle", 32'(cyc), 32'(r.cyc));
               check("dma_rdata", dma_rdata, r.data);
            end
         end else if (rdq.size() > 0 && rdq[0].cyc <= cyc) begin
            check("dma_rvalid_missing", 32'(dma_rvalid), 32'd1);
            void'(rdq.pop_front());
         end
      end
   end

   initial begin
      stim_t s, idle;
      int    r, bad;
      rst = 1'b1; mem_init = 1'b1;
      cpu_mem_read = 0; cpu_mem_write = 0; cpu_addr = 0; cpu_wdata = 0;
      dma_valid = 0; dma_we = 0; dma_addr = 0; dma_wdata = 0;
      rst0 = 1'b1; cpu_mem_read0 = 0; cpu_mem_write0 = 0; cpu_addr0 = 0; cpu_wdata0 = 0;
      dma_valid0 = 0; dma_we0 = 0; dma_addr0 = 0; dma_wdata0 = 0;
      for (int i = 0; i < 256; i++) ref_mem[i] = 32'h0;
      idle = mk(0, 0, 0, 0, 0, 0, 0, 0, 0);
      @(posedge clk); #1 mem_init = 1'b0;

      // Reset holds off both requesters.
      repeat (2) step(mk(1, 0, 1, 32'h40, 32'h11111111, 1, 1, 32'h44, 32'h22222222));
      @(negedge clk);
      check("dma_rdata_reset", dma_rdata, 32'h0);

      // DMA alone: write then read back.
      step(mk(0, 0, 0, 0, 0, 1, 1, 32'h40, 32'hDEADBEEF));
      step(mk(0, 0, 0, 0, 0, 1, 0, 32'h40, 0));
      step(idle); step(idle);

      // CPU alone: store then load.
      step(mk(0, 0, 1, 32'h10, 32'h12345678, 0, 0, 0, 0));
      step(mk(0, 1, 0, 32'h10, 0, 0, 0, 0, 0));
      step(idle);

      // Sustained contention: forced DMA grant every MAX_WAIT+1 cycles.
      repeat (15) step(mk(0, 1, 0, 32'h10, 0, 1, 0, 32'h40, 0));
      step(idle);

      // Forced DMA write then the stalled CPU load sees the new data.
      repeat (MAX_WAIT + 1) step(mk(0, 1, 0, 32'h20, 0, 1, 1, 32'h20, 32'hA5A5A5A5));
      step(mk(0, 1, 0, 32'h20, 0, 0, 0, 0, 0));
      step(idle);

      // Reset right after an accepted DMA read.
      step(mk(0, 0, 0, 0, 0, 1, 0, 32'h40, 0));
      step(mk(1, 0, 0, 0, 0, 0, 0, 0, 0));
      step(idle); step(idle);

      // Randomised traffic honouring the hold rules of both requesters.
      s = idle;
      for (int i = 0; i < 2000; i++) begin
         if (!prev_stall) begin
            r = int'($urandom_range(0, 9));
            s.cr = (r < 3);
            s.cw = (r >= 3 && r < 6);
            s.ca = 32'($urandom_range(0, 7)) << 2;
            s.cwd = $urandom;
         end
         if (!prev_hold) begin
            s.dv = ($urandom_range(0, 9) < 6);
            s.dwe = 1'($urandom_range(0, 1));
            s.da = 32'($urandom_range(0, 7)) << 2;
            s.dwd = $urandom;
         end
         s.rst = ($urandom_range(0, 99) == 0);
         step(s);
      end
      repeat (3) step(idle);

      // MAX_WAIT=0 instance: DMA wins every contended cycle, CPU resumes once DMA drops.
      @(posedge clk); #1;
      rst0 = 1'b0; cpu_mem_read0 = 1'b1; cpu_addr0 = 32'h90; dma_valid0 = 1'b1; dma_addr0 = 32'h80;
      for (int i = 0; i < 6; i++) begin
         @(negedge clk);
         check("mw0_dma_ready", 32'(dma_ready0), 32'd1);
         check("mw0_cpu_stall", 32'(cpu_stall0), 32'd1);
         check("mw0_mem_addr", mem_addr0, 32'h80);
         @(posedge clk); #1;
      end
      dma_valid0 = 1'b0;
      @(negedge clk);
      check("mw0_dma_ready_off", 32'(dma_ready0), 32'd0);
      check("mw0_cpu_stall_off", 32'(cpu_stall0), 32'd0);
      check("mw0_mem_addr_cpu", mem_addr0, 32'h90);

      repeat (3) @(negedge clk);
      check("rd_queue_drained", 32'(rdq.size()), 32'd0);
      bad = 0;
      for (int i = 0; i < 256; i++) if (dmem[i] !== ref_mem[i]) bad++;
      check("dmem_contents_bad_words", 32'(bad), 32'd0);

      $display("Result: errors=%0d of %0d checks", errs, checks);
      $finish;
   end
endmodule

// File: doc/dmem_arbiter.md
# dmem_arbiter

Single-cycle arbiter that shares the one data-memory port (dmem: combinational read, write on clock edge) between the pipeline MEM stage and a secondary DMA/loader requester. The CPU has priority. A starvation counter forces a DMA grant after a bounded wait, and the CPU MEM stage is stalled for that cycle. The block sits between mem_stage and dmem and drives the dmem port directly.

## Interface
- MAX_WAIT, 4, number of consecutive contended cycles the DMA may lose before it is force-granted; legal range 0..15 (0 = DMA always wins contention)
- clk  input  1  core clock, all state updates on rising edge
- rst  input  1  reset; synchronous, active-high
- cpu_mem_read  input  1  MEM stage load request
- cpu_mem_write  input  1  MEM stage store request
- cpu_addr  input  32  MEM stage byte address (ALU result)
- cpu_wdata  input  32  MEM stage store data
- cpu_rdata  output  32  load data to MEM stage (combinational from mem_rd)
- cpu_stall  output  1  MEM stage must hold; its request is not performed this cycle
- dma_valid  input  1  DMA request pending; addr/we/wdata must stay stable while valid && !ready
- dma_we  input  1  1 = write, 0 = read
- dma_addr  input  32  DMA byte address
- dma_wdata  input  32  DMA write data
- dma_ready  output  1  DMA request accepted this cycle
- dma_rvalid  output  1  registered read data valid, one-cycle pulse
- dma_rdata  output  32  registered read data
- mem_we  output  1  dmem write enable
- mem_addr  output  32  dmem address
- mem_wd  output  32  dmem write data
- mem_rd  input  32  dmem read data (combinational)

## Operation
- cpu_req = cpu_mem_read | cpu_mem_write.
- Grant is decided combinationally each cycle from inputs and the registered wait_cnt (4-bit, saturating at MAX_WAIT):
  - rst=1: no grant; dma_ready=0, cpu_stall=0, mem_we=0, mem_addr=cpu_addr.
  - !cpu_req && !dma_valid: idle; mem port is driven from CPU fields with mem_we=0.
  - cpu_req && !dma_valid: CPU granted.
  - !cpu_req && dma_valid: DMA granted.
  - cpu_req && dma_valid && wait_cnt < MAX_WAIT: CPU granted; wait_cnt increments.
  - cpu_req && dma_valid && wait_cnt == MAX_WAIT: DMA granted; cpu_stall=1.
- wait_cnt update:
  - Cleared to 0 on any DMA grant and on any cycle with dma_valid=0.
  - Otherwise incremented, as above.
- CPU grant: mem_we=cpu_mem_write, mem_addr=cpu_addr, mem_wd=cpu_wdata, cpu_stall=0, dma_ready=0.
- DMA grant: dma_ready=1, mem_we=dma_we, mem_addr=dma_addr, mem_wd=dma_wdata.
- cpu_rdata = mem_rd at all times. The MEM stage ignores it while cpu_stall=1.
- cpu_stall is asserted only in a forced-DMA cycle. While stalled, the MEM stage holds its request, which is re-presented next cycle.
- Guarantee for MAX_WAIT≥1: after a forced DMA grant, wait_cnt=0. The CPU therefore gets at least MAX_WAIT consecutive grants under sustained contention and is never stalled two cycles in a row.
- Guarantee for MAX_WAIT=0: DMA wins every contended cycle.
- DMA read accepted (dma_ready && !dma_we): dma_rdata <= mem_rd, and dma_rvalid pulses high the next cycle.
- DMA write accepted: no rvalid.

## Timing
- Reset values:
  - Registered state: wait_cnt=0, dma_rvalid=0, dma_rdata=0.
  - Combinational outputs during rst: dma_ready=0, cpu_stall=0, mem_we=0.
- Reset asserted mid-operation: any in-flight handshake is dropped, no memory write occurs that cycle, and a pending rvalid is cleared on the reset edge.
- Latency:
  - CPU access: 0 cycles (combinational path cpu_* -> mem_* -> cpu_rdata).
  - DMA write: committed at the edge ending the ready cycle.
  - DMA read: data on dma_rdata with dma_rvalid=1 exactly 1 cycle after the ready cycle, held until the next accepted read.
- Back-to-back DMA reads produce back-to-back rvalid pulses.
- Same-address ordering: a write granted in cycle N is visible to any read granted in cycle N+1, from either requester.
- Simultaneous CPU store and DMA write to the same address: the granted one writes; the loser is performed in a later cycle and overwrites.

## Test plan
- Reset: rst=1 for 2 cycles with cpu_mem_write=1 and dma_valid=1 -> mem_we=0, dma_ready=0, cpu_stall=0, dma_rvalid=0 throughout, and dmem contents unchanged.
- DMA alone: DMA writes 0xDEADBEEF to 0x40, then reads 0x40 -> dma_ready=1 in both cycles, and in the cycle after the read dma_rvalid=1 with dma_rdata=0xDEADBEEF.
- CPU alone: CPU stores 0x12345678 to 0x10, then loads 0x10 -> cpu_stall never asserted; cpu_rdata=0x12345678 in the same cycle as the load.
- Starvation, MAX_WAIT=4: cpu_mem_read held high with dma_valid held high -> dma_ready low for 4 cycles, high in cycle 5 together with cpu_stall=1, then the pattern repeats every 5 cycles.
- MAX_WAIT=0 contention -> DMA granted and cpu_stall=1 in every contended cycle; CPU granted in the first cycle with dma_valid=0.
- Ordering and reset mid-read:
  - Forced DMA write of 0xA5A5A5A5 to 0x20 while the CPU loads 0x20 -> the CPU load completes the next cycle returning 0xA5A5A5A5.
  - DMA read accepted, then rst=1 the next cycle -> dma_rvalid=0 after the reset edge.
